// File: rtl/xif_result_arbiter.sv
// xif_result_arbiter: round-robin arbiter sharing one CORE-V-XIF result channel
// among NUM_COPROC coprocessors through a registered one-entry output stage.
module xif_result_arbiter #(
  parameter int NUM_COPROC = 2,
  parameter int RESULT_W   = 64,
  parameter int SRC_W      = NUM_COPROC > 1 ? $clog2(NUM_COPROC) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_COPROC-1:0] cop_result_valid_i,
  output logic [NUM_COPROC-1:0] cop_result_ready_o,
  input  logic [RESULT_W-1:0]   cop_result_i [NUM_COPROC],
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic [RESULT_W-1:0]   result_o,
  output logic [SRC_W-1:0]      result_src_o,
  output logic [15:0]           result_count_o
);
  logic                r_out_valid;
  logic [RESULT_W-1:0] r_out_data;
  logic [SRC_W-1:0]    r_src;
  logic [SRC_W-1:0]    r_rr_ptr;
  logic [15:0]         r_count;
  logic                w_load;
  logic                w_found;
  logic [SRC_W-1:0]    w_gnt;

  function automatic logic [SRC_W-1:0] wrap_idx(input int v);
    return SRC_W'(v % NUM_COPROC);
  endfunction

  assign w_load = !r_out_valid || result_ready_i;

  // first valid requester at or after the pointer, modulo NUM_COPROC
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int k = 0; k < NUM_COPROC; k++) begin
      if (!w_found && cop_result_valid_i[wrap_idx(int'(r_rr_ptr) + k)]) begin
        w_found = 1'b1;
        w_gnt   = wrap_idx(int'(r_rr_ptr) + k);
      end
    end
  end

  always_comb begin
    cop_result_ready_o = '0;
    if (rst_ni && w_load && w_found) cop_result_ready_o[w_gnt] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_src       <= '0;
      r_rr_ptr    <= '0;
      r_count     <= '0;
    end else begin
      if (w_load) begin
        r_out_valid <= w_found;
        if (w_found) begin
          r_out_data <= cop_result_i[w_gnt];
          r_src      <= w_gnt;
          r_rr_ptr   <= wrap_idx(int'(w_gnt) + 1);
        end
      end
      if (r_out_valid && result_ready_i) r_count <= r_count + 16'd1;
    end
  end

  assign result_valid_o = r_out_valid;
  assign result_o       = r_out_data;
  assign result_src_o   = r_src;
  assign result_count_o = r_count;
endmodule
